// File: rtl/floo_pkg.sv
// Shared types for the link-level flow-control blocks.
package floo_pkg;

    typedef enum logic {
        Idle,
        Locked
    } vc_sched_state_e;

endpackage

// File: rtl/floo_credit_counter.sv
// Credit counter for one virtual channel toward its downstream input FIFO.
module floo_credit_counter #(
    parameter int unsigned NumCredits = 4,
    parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                decr_i,
    input  logic                incr_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                avail_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

    logic [CntWidth-1:0] cnt_d, cnt_q;

    // A credit returned into a full counter is dropped so the count never exceeds the FIFO depth.
    always_comb begin
        cnt_d = cnt_q;
        if (decr_i && !incr_i) begin
            cnt_d = cnt_q - CntWidth'(1);
        end else if (incr_i && !decr_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= MaxCnt;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign avail_o = (cnt_q != '0);

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(incr_i && (cnt_q == MaxCnt)));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(decr_i && (cnt_q == '0)));
    assert property (@(posedge clk_i) disable iff (!rst_ni) (cnt_q <= MaxCnt));

endmodule

// File: rtl/floo_vc_credit_scheduler.sv
// Shares one physical link between several VC queues using per-VC credits,
// round-robin selection and optional wormhole locking; the link flit is registered.
module floo_vc_credit_scheduler
    import floo_pkg::*;
#(
    parameter int unsigned  NumVirtChannels = 2,
    parameter type          flit_t          = logic,
    parameter int unsigned  NumCredits      = 4,
    parameter bit           WormholeLock    = 1'b1,
    parameter int unsigned  CntWidth        = $clog2(NumCredits + 1),
    localparam int unsigned VcIdWidth       = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NumVirtChannels-1:0]                 valid_i,
    output logic [NumVirtChannels-1:0]                 ready_o,
    input  flit_t [NumVirtChannels-1:0]                data_i,
    input  logic [NumVirtChannels-1:0]                 last_i,
    input  logic [NumVirtChannels-1:0]                 credit_i,
    output logic                                       valid_o,
    output logic [VcIdWidth-1:0]                       vc_id_o,
    output flit_t                                      data_o,
    output logic [NumVirtChannels-1:0][CntWidth-1:0]   credits_o
);

    vc_sched_state_e state_d, state_q;
    logic [VcIdWidth-1:0] lock_vc_d, lock_vc_q;
    logic [VcIdWidth-1:0] rr_ptr_d, rr_ptr_q;
    logic                 valid_d, valid_q;
    logic [VcIdWidth-1:0] vc_id_d, vc_id_q;
    flit_t                data_d, data_q;

    logic [NumVirtChannels-1:0] avail;
    logic [NumVirtChannels-1:0] elig;
    logic [NumVirtChannels-1:0] grant;
    logic [VcIdWidth-1:0]       gnt_idx;
    logic                       gnt_valid;

    function automatic logic [VcIdWidth-1:0] wrap_add(input logic [VcIdWidth-1:0] idx,
                                                      input int unsigned ofs);
        return VcIdWidth'((32'(idx) + ofs) % NumVirtChannels);
    endfunction

    for (genvar gi = 0; gi < NumVirtChannels; gi++) begin : gen_vc
        floo_credit_counter #(
            .NumCredits (NumCredits),
            .CntWidth   (CntWidth)
        ) u_credit_counter (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .decr_i  (grant[gi]),
            .incr_i  (credit_i[gi]),
            .cnt_o   (credits_o[gi]),
            .avail_o (avail[gi])
        );

        assert property (@(posedge clk_i) disable iff (!rst_ni)
            ready_o[gi] |-> (valid_i[gi] && (credits_o[gi] != '0)));
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_i[gi] && !ready_o[gi]) |=> valid_i[gi]);
    end

    // Credits returned this cycle only count from the next cycle on.
    assign elig = valid_i & avail;

    // Locked: only the owning VC may go. Idle: first eligible VC at or after rr_ptr.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (state_q == Locked) begin
            gnt_idx   = lock_vc_q;
            gnt_valid = elig[lock_vc_q];
        end else begin
            for (int unsigned i = 0; i < NumVirtChannels; i++) begin
                if (!gnt_valid && elig[wrap_add(rr_ptr_q, i)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = wrap_add(rr_ptr_q, i);
                end
            end
        end
    end

    always_comb begin
        grant          = '0;
        grant[gnt_idx] = gnt_valid;
    end

    assign ready_o = grant;

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        if (gnt_valid) begin
            if (last_i[gnt_idx] || !WormholeLock) begin
                state_d  = Idle;
                rr_ptr_d = wrap_add(gnt_idx, 1);
            end else begin
                state_d   = Locked;
                lock_vc_d = gnt_idx;
            end
        end
    end

    // Link register: payload and VC id hold while the link idles.
    always_comb begin
        valid_d = gnt_valid;
        vc_id_d = vc_id_q;
        data_d  = data_q;
        if (gnt_valid) begin
            vc_id_d = gnt_idx;
            data_d  = data_i[gnt_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
            valid_q   <= 1'b0;
            vc_id_q   <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            valid_q   <= valid_d;
            vc_id_q   <= vc_id_d;
            data_q    <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign vc_id_o = (NumVirtChannels > 1) ? vc_id_q : '0;
    assign data_o  = data_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ready_o));

endmodule

// File: tb/tb_floo_vc_credit_scheduler.sv
// Bench for floo_vc_credit_scheduler: a locking and a non-locking instance checked every
// cycle against a queue/arithmetic model, plus hand-computed link sequences per scenario.
module tb_floo_vc_credit_scheduler;

    localparam int N  = 2;
    localparam int NC = 4;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      valid  [2];
    logic [1:0]      last   [2];
    logic [1:0]      credit [2];
    logic [1:0]      ready  [2];
    logic [1:0][7:0] data   [2];
    logic            lvalid [2];
    logic [0:0]      lvc    [2];
    logic [7:0]      ldata  [2];
    logic [1:0][2:0] creds  [2];

    floo_vc_credit_scheduler #(
        .NumVirtChannels (2),
        .flit_t          (logic [7:0]),
        .NumCredits      (NC),
        .WormholeLock    (1'b1)
    ) u_dut_lock (
        .clk_i (clk), .rst_ni (rst_ni), .valid_i (valid[0]), .ready_o (ready[0]),
        .data_i (data[0]), .last_i (last[0]), .credit_i (credit[0]), .valid_o (lvalid[0]),
        .vc_id_o (lvc[0]), .data_o (ldata[0]), .credits_o (creds[0])
    );

    floo_vc_credit_scheduler #(
        .NumVirtChannels (2),
        .flit_t          (logic [7:0]),
        .NumCredits      (NC),
        .WormholeLock    (1'b0)
    ) u_dut_nolock (
        .clk_i (clk), .rst_ni (rst_ni), .valid_i (valid[1]), .ready_o (ready[1]),
        .data_i (data[1]), .last_i (last[1]), .credit_i (credit[1]), .valid_o (lvalid[1]),
        .vc_id_o (lvc[1]), .data_o (ldata[1]), .credits_o (creds[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", name, inst, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt  [2][2];
    int m_rr   [2];
    int m_lock [2];   // -1 = no packet in progress
    int m_valid[2];
    int m_vc   [2];
    int m_data [2];

    function automatic bit lock_mode(input int i);
        return i == 0;
    endfunction

    task automatic model_reset(input int i);
        for (int v = 0; v < N; v++) m_cnt[i][v] = NC;
        m_rr[i] = 0; m_lock[i] = -1; m_valid[i] = 0; m_vc[i] = 0; m_data[i] = 0;
    endtask

    function automatic int model_grant(input int i);
        int g;
        bit el [2];
        g = -1;
        for (int v = 0; v < N; v++) el[v] = (valid[i][v] === 1'b1) && (m_cnt[i][v] > 0);
        if (m_lock[i] >= 0) begin
            if (el[m_lock[i]]) g = m_lock[i];
        end else begin
            for (int k = 0; k < N; k++)
                if (g < 0 && el[(m_rr[i] + k) % N]) g = (m_rr[i] + k) % N;
        end
        return g;
    endfunction

    task automatic model_step(input int i, input int g);
        for (int v = 0; v < N; v++) begin
            int nxt;
            nxt = m_cnt[i][v] - ((g == v) ? 1 : 0) + ((credit[i][v] === 1'b1) ? 1 : 0);
            m_cnt[i][v] = (nxt > NC) ? NC : nxt;
        end
        m_valid[i] = (g >= 0) ? 1 : 0;
        if (g >= 0) begin
            m_vc[i]   = g;
            m_data[i] = int'(data[i][g]);
            if (last[i][g] || !lock_mode(i)) begin
                m_lock[i] = -1;
                m_rr[i]   = (g + 1) % N;
            end else begin
                m_lock[i] = g;
            end
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_ni) begin
                    model_reset(i);
                    check("reset_valid_o", i, int'(lvalid[i]), m_valid[i]);
                    check("reset_vc_id_o", i, int'(lvc[i]), m_vc[i]);
                    check("reset_data_o", i, int'(ldata[i]), m_data[i]);
                    check("reset_credits0", i, int'(creds[i][0]), m_cnt[i][0]);
                    check("reset_credits1", i, int'(creds[i][1]), m_cnt[i][1]);
                end else begin
                    int g;
                    g = model_grant(i);
                    check("ready_o", i, int'(ready[i]), (g < 0) ? 0 : (1 << g));
                    check("valid_o", i, int'(lvalid[i]), m_valid[i]);
                    check("vc_id_o", i, int'(lvc[i]), m_vc[i]);
                    check("data_o", i, int'(ldata[i]), m_data[i]);
                    check("credits0", i, int'(creds[i][0]), m_cnt[i][0]);
                    check("credits1", i, int'(creds[i][1]), m_cnt[i][1]);
                    model_step(i, g);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [8:0] fq [4][$];     // {last, data}, index inst*2+vc
    logic [1:0] man_cred [2];
    bit         auto_ret [2];
    logic [1:0] prev_gnt [2];
    int         link_log [2][$];
    logic [1:0] rdy_log  [2][$];

    task automatic push(input int i, input int v, input int d, input bit l);
        fq[i*2+v].push_back({l, 8'(d)});
    endtask

    // One cycle: drive at edge+1, observe grants at edge+4, retire at next edge+1.
    task automatic tick();
        logic [1:0] gnt [2];
        for (int i = 0; i < 2; i++) begin
            for (int v = 0; v < 2; v++) begin
                int qi;
                qi = i*2 + v;
                valid[i][v] = (fq[qi].size() > 0);
                data[i][v]  = valid[i][v] ? fq[qi][0][7:0] : 8'h00;
                last[i][v]  = valid[i][v] ? fq[qi][0][8] : 1'b0;
            end
            credit[i] = man_cred[i] | (auto_ret[i] ? prev_gnt[i] : 2'b00);
        end
        #3;
        for (int i = 0; i < 2; i++) begin
            gnt[i] = ready[i];
            rdy_log[i].push_back(ready[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int v = 0; v < 2; v++)
                if (gnt[i][v]) void'(fq[i*2+v].pop_front());
            prev_gnt[i] = gnt[i];
            man_cred[i] = 2'b00;
            link_log[i].push_back(lvalid[i] ? int'(lvc[i]) : -1);
        end
    endtask

    task automatic do_reset();
        #2 rst_ni = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid[i] = '0; last[i] = '0; credit[i] = '0; data[i] = '0;
            man_cred[i] = '0; auto_ret[i] = 1'b0; prev_gnt[i] = '0;
            link_log[i].delete();
            rdy_log[i].delete();
        end
        for (int q = 0; q < 4; q++) fq[q].delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    initial begin : stimulus
        int exp_alt  [6];
        int exp_lock [6];
        int exp_t5   [12];
        int nflits;
        exp_lock = '{0, 0, 0, 1, 1, -1};
        exp_alt  = '{0, 1, 0, 1, 0, -1};
        exp_t5   = '{1, 1, 1, 1, -1, -1, -1, -1, 1, -1, 1, 0};
        for (int i = 0; i < 2; i++) begin
            valid[i] = '0; last[i] = '0; credit[i] = '0; data[i] = '0;
            man_cred[i] = '0; auto_ret[i] = 1'b0; prev_gnt[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        check("lit_reset_credits", 0, int'(creds[0][0]), 4);

        // 1: VC0 alone, six single-flit packets, no credits returned.
        for (int k = 0; k < 6; k++) push(0, 0, 'h10 + k, 1'b1);
        repeat (8) tick();
        nflits = 0;
        foreach (link_log[0][k]) if (link_log[0][k] >= 0) nflits++;
        check("lit_t1_flits", 0, nflits, 4);
        check("lit_t1_first", 0, link_log[0][0], 0);
        check("lit_t1_idle", 0, link_log[0][4], -1);
        check("lit_t1_cnt_empty", 0, int'(creds[0][0]), 0);
        check("lit_t1_ready_off", 0, int'(ready[0][0]), 0);
        check("lit_t1_last_data", 0, int'(ldata[0]), 'h13);
        man_cred[0] = 2'b01;
        repeat (3) tick();
        check("lit_t1_credit_cyc", 0, link_log[0][8], -1);
        check("lit_t1_one_more", 0, link_log[0][9], 0);
        check("lit_t1_then_idle", 0, link_log[0][10], -1);
        check("lit_t1_data5", 0, int'(ldata[0]), 'h14);
        repeat (5) begin
            man_cred[0] = 2'b01;
            tick();
        end
        check("lit_t1_refilled", 0, int'(creds[0][0]), 4);

        // 2: both VCs streaming single-flit packets, credits echoed back.
        do_reset();
        auto_ret[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(0, 0, 'h20 + k, 1'b1);
            push(0, 1, 'h30 + k, 1'b1);
        end
        repeat (9) tick();
        for (int k = 0; k < 8; k++) check("lit_t2_alternate", 0, link_log[0][k], k % 2);
        check("lit_t2_drained", 0, link_log[0][8], -1);
        check("lit_t2_cnt0", 0, int'(creds[0][0]), 4);
        check("lit_t2_cnt1", 0, int'(creds[0][1]), 4);

        // 3+4: 3-flit packet on VC0 against two single-flit packets on VC1.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            auto_ret[i] = 1'b1;
            push(i, 0, 'h40, 1'b0);
            push(i, 0, 'h41, 1'b0);
            push(i, 0, 'h42, 1'b1);
            push(i, 1, 'h50, 1'b1);
            push(i, 1, 'h51, 1'b1);
        end
        repeat (6) tick();
        for (int k = 0; k < 6; k++) begin
            check("lit_t3_locked_seq", 0, link_log[0][k], exp_lock[k]);
            check("lit_t4_interleave", 1, link_log[1][k], exp_alt[k]);
        end
        for (int k = 0; k < 3; k++) check("lit_t3_vc1_held", 0, int'(rdy_log[0][k][1]), 0);

        // 5: locked on VC1 that runs out of credits while VC0 waits.
        do_reset();
        for (int k = 0; k < 6; k++) push(0, 1, 'h60 + k, k == 5);
        repeat (4) tick();
        push(0, 0, 'h70, 1'b1);
        repeat (3) tick();
        man_cred[0] = 2'b10;
        repeat (2) tick();
        man_cred[0] = 2'b10;
        repeat (3) tick();
        for (int k = 0; k < 12; k++) check("lit_t5_seq", 0, link_log[0][k], exp_t5[k]);
        for (int k = 4; k < 9; k++) check("lit_t5_vc0_blocked", 0, int'(rdy_log[0][k][0]), 0);
        check("lit_t5_final_data", 0, int'(ldata[0]), 'h70);

        // 6: grant and credit together, then reset in the middle of a packet.
        do_reset();
        for (int k = 0; k < 3; k++) push(0, 0, 'h80 + k, 1'b0);
        repeat (2) tick();
        check("lit_t6_cnt_before", 0, int'(creds[0][0]), 2);
        man_cred[0] = 2'b01;
        tick();
        check("lit_t6_cnt_same", 0, int'(creds[0][0]), 2);
        push(0, 0, 'h83, 1'b0);
        tick();
        check("lit_t6_link_busy", 0, int'(lvalid[0]), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("lit_t6_async_valid", 0, int'(lvalid[0]), 0);
        check("lit_t6_async_cnt0", 0, int'(creds[0][0]), 4);
        check("lit_t6_async_cnt1", 0, int'(creds[0][1]), 4);
        do_reset();
        push(0, 1, 'h90, 1'b1);
        tick();
        check("lit_t6_unlocked", 0, link_log[0][0], 1);
        check("lit_t6_data", 0, int'(ldata[0]), 'h90);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
